// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the simulation control sequencer.
// Holds the FSM state enum, the fatal code enum and the watchdog codes.
package sim_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE         = 2'd0,
        FC_WATCHDOG     = 2'd1,
        FC_IDLE_TIMEOUT = 2'd2,
        FC_GLOBAL       = 2'd3
    } fatal_code_t;

    localparam logic [7:0] WD_CONTINUE = 8'h00;
    localparam logic [7:0] WD_QUIT     = 8'hFF;

endpackage

// File: rtl/sim_ctrl_dump_window.sv
// Wave-dump window tracker; only compiled when SIM_CTRL_TRACE_EN is defined.
// Ports: clock, reset (sync, active-high), active (RUN/DRAIN), stop
// (entering DONE/FAIL), cnt, dump_start, dump_end -> dump_en.
`ifdef SIM_CTRL_TRACE_EN
module sim_ctrl_dump_window #(
    parameter int CYCLE_W = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               active,
    input  logic               stop,
    input  logic [CYCLE_W-1:0] cnt,
    input  logic [CYCLE_W-1:0] dump_start,
    input  logic [CYCLE_W-1:0] dump_end,
    output logic               dump_en
);

    // The window opens at most once per run.
    logic started;

    always_ff @(posedge clock) begin
        if (reset) begin
            dump_en <= 1'b0;
            started <= 1'b0;
        end else if (active) begin
            if (stop || (dump_end != '0 && cnt == dump_end)) begin
                dump_en <= 1'b0;
            end else if (!started &&
                         (dump_start == '0 || cnt == dump_start)) begin
                dump_en <= 1'b1;
                started <= 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/sim_ctrl_sequencer.sv
// Simulation control sequencer: INIT -> RUN -> (DRAIN) -> DONE / FAIL.
// Inputs: clock, reset (sync, active-high), global_timeout,
// timeout_after_quit, dump_start, dump_end, wd_status, idle.
// Outputs: init_flag, wd_req, finish, fatal, fatal_code, done, failed,
// dump_en, cycle, quit_cycle. Macro SIM_CTRL_TRACE_EN enables dump_en.
module sim_ctrl_sequencer
    import sim_ctrl_pkg::*;
#(
    parameter int CYCLE_W     = 64,
    parameter int INIT_CYCLES = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CYCLE_W-1:0] global_timeout,
    input  logic [CYCLE_W-1:0] timeout_after_quit,
    input  logic [CYCLE_W-1:0] dump_start,
    input  logic [CYCLE_W-1:0] dump_end,
    input  logic [7:0]         wd_status,
    input  logic               idle,
    output logic               init_flag,
    output logic               wd_req,
    output logic               finish,
    output logic               fatal,
    output logic [1:0]         fatal_code,
    output logic               done,
    output logic               failed,
    output logic               dump_en,
    output logic [CYCLE_W-1:0] cycle,
    output logic [CYCLE_W-1:0] quit_cycle
);

    localparam logic [7:0]         INIT_LAST = 8'(INIT_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] ONE       = 1;

    state_t              state, state_n;
    fatal_code_t         code_q, code_n;
    logic [7:0]          init_cnt, init_cnt_n;
    logic [CYCLE_W-1:0]  cycle_n, quit_n;
    logic [CYCLE_W-1:0]  cnt, drain_limit;
    logic                finish_n, fatal_n, done_n, failed_n;
    logic                global_hit, wd_bad, active;

    assign cnt         = cycle + ONE;
    // Wraps at CYCLE_W bits by construction.
    assign drain_limit = quit_cycle + timeout_after_quit;
    assign global_hit  = (global_timeout != '0) && (cnt == global_timeout);
    assign wd_bad      = (wd_status != WD_CONTINUE) && (wd_status != WD_QUIT);
    assign active      = (state == ST_RUN) || (state == ST_DRAIN);

    assign init_flag  = (state == ST_INIT);
    assign wd_req     = (state == ST_RUN);
    assign fatal_code = code_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_INIT;
            init_cnt   <= '0;
            cycle      <= '0;
            quit_cycle <= '0;
            code_q     <= FC_NONE;
            finish     <= 1'b0;
            fatal      <= 1'b0;
            done       <= 1'b0;
            failed     <= 1'b0;
        end else begin
            state      <= state_n;
            init_cnt   <= init_cnt_n;
            cycle      <= cycle_n;
            quit_cycle <= quit_n;
            code_q     <= code_n;
            finish     <= finish_n;
            fatal      <= fatal_n;
            done       <= done_n;
            failed     <= failed_n;
        end
    end

    always_comb begin
        state_n    = state;
        init_cnt_n = init_cnt;
        cycle_n    = cycle;
        quit_n     = quit_cycle;
        code_n     = code_q;
        finish_n   = 1'b0;
        fatal_n    = 1'b0;
        done_n     = done;
        failed_n   = failed;
        unique case (state)
            ST_INIT: begin
                if (init_cnt == INIT_LAST) begin
                    state_n = ST_RUN;
                end else begin
                    init_cnt_n = init_cnt + 8'd1;
                end
            end
            ST_RUN: begin
                cycle_n = cnt;
                if (wd_status == WD_QUIT && idle) begin
                    quit_n   = cnt;
                    state_n  = ST_DONE;
                    finish_n = 1'b1;
                    done_n   = 1'b1;
                end else if (wd_bad) begin
                    state_n  = ST_FAIL;
                    code_n   = FC_WATCHDOG;
                    fatal_n  = 1'b1;
                    failed_n = 1'b1;
                end else if (global_hit) begin
                    state_n  = ST_FAIL;
                    code_n   = FC_GLOBAL;
                    fatal_n  = 1'b1;
                    failed_n = 1'b1;
                end else if (wd_status == WD_QUIT) begin
                    quit_n  = cnt;
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cycle_n = cnt;
                if (idle) begin
                    state_n  = ST_DONE;
                    finish_n = 1'b1;
                    done_n   = 1'b1;
                end else if (cnt > drain_limit) begin
                    state_n  = ST_FAIL;
                    code_n   = FC_IDLE_TIMEOUT;
                    fatal_n  = 1'b1;
                    failed_n = 1'b1;
                end else if (global_hit) begin
                    state_n  = ST_FAIL;
                    code_n   = FC_GLOBAL;
                    fatal_n  = 1'b1;
                    failed_n = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

`ifdef SIM_CTRL_TRACE_EN
    logic stop;
    assign stop = active && (state_n == ST_DONE || state_n == ST_FAIL);

    sim_ctrl_dump_window #(
        .CYCLE_W (CYCLE_W)
    ) u_dump (
        .clock      (clock),
        .reset      (reset),
        .active     (active),
        .stop       (stop),
        .cnt        (cnt),
        .dump_start (dump_start),
        .dump_end   (dump_end),
        .dump_en    (dump_en)
    );
`else
    // Window inputs are deliberately left unconnected to any logic.
    logic dump_unused;
    assign dump_unused = ^{dump_start, dump_end, active};
    assign dump_en     = 1'b0;
`endif

endmodule

// File: tb/tb_sim_ctrl_sequencer.sv
// Directed self-checking bench for sim_ctrl_sequencer.
// Covers reset, clean quit, drain, watchdog, priority, reset mid-drain.
module tb_sim_ctrl_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] global_timeout = '0;
    logic [63:0] timeout_after_quit = 64'd5;
    logic [63:0] dump_start = 64'd3;
    logic [63:0] dump_end = 64'd6;
    logic [7:0]  wd_status = 8'h00;
    logic        idle = 1'b0;
    logic        init_flag, wd_req, finish, fatal, done, failed, dump_en;
    logic [1:0]  fatal_code;
    logic [63:0] cycle, quit_cycle;

    int n_checks = 0;
    int n_pass   = 0;

    sim_ctrl_sequencer dut (
        .clock              (clock),
        .reset              (reset),
        .global_timeout     (global_timeout),
        .timeout_after_quit (timeout_after_quit),
        .dump_start         (dump_start),
        .dump_end           (dump_end),
        .wd_status          (wd_status),
        .idle               (idle),
        .init_flag          (init_flag),
        .wd_req             (wd_req),
        .finish             (finish),
        .fatal              (fatal),
        .fatal_code         (fatal_code),
        .done               (done),
        .failed             (failed),
        .dump_en            (dump_en),
        .cycle              (cycle),
        .quit_cycle         (quit_cycle)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic exp_dump(input int n);
`ifdef SIM_CTRL_TRACE_EN
        return (n >= 3 && n <= 5);
`else
        return 1'b0;
`endif
    endfunction

    // One RUN/DRAIN cycle: drive at negedge, observe 1ns after posedge.
    task automatic step(input logic [7:0] wd, input logic id);
        @(negedge clock);
        wd_status = wd;
        idle      = id;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_run(input int n);
        for (int i = 0; i < n; i++) step(8'h00, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        wd_status = 8'h00;
        idle      = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_init_flag", init_flag, 1);
        chk("rst_cycle", cycle, 0);
        chk("rst_quit", quit_cycle, 0);
        chk("rst_pulses", {wd_req, finish, fatal}, 0);
        chk("rst_sticky", {done, failed, fatal_code, dump_en}, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("init_hold", init_flag, 1);
        @(posedge clock);
        #1;
        chk("run_entry", {init_flag, wd_req}, 2'b01);
        chk("run_cycle0", cycle, 0);
    endtask

    initial begin
        // Clean quit at cycle 10 with dump window tracking.
        do_reset();
        for (int n = 1; n <= 9; n++) begin
            step(8'h00, 1'b1);
            chk($sformatf("dump_c%0d", n), dump_en, exp_dump(n));
        end
        chk("cq_cycle9", cycle, 9);
        chk("cq_no_finish", finish, 0);
        step(8'hFF, 1'b1);
        chk("cq_finish", finish, 1);
        chk("cq_done", done, 1);
        chk("cq_quit", quit_cycle, 10);
        chk("cq_cycle", cycle, 10);
        chk("cq_nofatal", {fatal, failed}, 0);
        chk("cq_wdreq", wd_req, 0);
        chk("cq_dump_off", dump_en, 0);
        step(8'h00, 1'b0);
        chk("cq_pulse_end", finish, 0);
        chk("cq_frozen", cycle, 10);
        chk("cq_sticky", done, 1);

        // Drain then idle at cycle 14.
        do_reset();
        idle_run(9);
        step(8'hFF, 1'b0);
        chk("dr_enter", {finish, done, wd_req}, 0);
        chk("dr_quit", quit_cycle, 10);
        step(8'h55, 1'b0);
        chk("dr_wdreq11", wd_req, 0);
        step(8'h55, 1'b0);
        step(8'h55, 1'b0);
        chk("dr_nofatal", {fatal, failed}, 0);
        step(8'h55, 1'b1);
        chk("dr_finish", finish, 1);
        chk("dr_cycle", cycle, 14);
        chk("dr_done", done, 1);

        // Drain with idle never rising: fatal at 16.
        do_reset();
        idle_run(9);
        step(8'hFF, 1'b0);
        idle_run(5);
        chk("it_cycle15", cycle, 15);
        chk("it_nofatal15", fatal, 0);
        step(8'h00, 1'b0);
        chk("it_fatal", fatal, 1);
        chk("it_code", fatal_code, 2);
        chk("it_cycle", cycle, 16);
        chk("it_failed", failed, 1);
        step(8'h00, 1'b1);
        chk("it_pulse_end", fatal, 0);
        chk("it_frozen", {cycle[7:0], fatal_code, done}, {8'd16, 2'd2, 1'b0});

        // Watchdog fault at cycle 7.
        do_reset();
        idle_run(6);
        step(8'h01, 1'b0);
        chk("wd_fatal", fatal, 1);
        chk("wd_code", fatal_code, 1);
        chk("wd_cycle", cycle, 7);
        chk("wd_failed", failed, 1);
        step(8'h00, 1'b0);
        step(8'hFF, 1'b1);
        chk("wd_frozen", cycle, 7);
        chk("wd_terminal", {fatal, finish, done, wd_req}, 0);

        // Quit beats global timeout on the same cycle.
        global_timeout = 64'd10;
        do_reset();
        idle_run(9);
        step(8'hFF, 1'b1);
        chk("pr_finish", finish, 1);
        chk("pr_nofatal", {fatal, failed, fatal_code}, 0);

        // Global timeout alone.
        do_reset();
        idle_run(9);
        chk("gt_before", fatal, 0);
        step(8'h00, 1'b0);
        chk("gt_fatal", fatal, 1);
        chk("gt_code", fatal_code, 3);
        chk("gt_cycle", cycle, 10);
        global_timeout = '0;

        // Reset mid-drain, then a normal run.
        do_reset();
        idle_run(9);
        step(8'hFF, 1'b0);
        step(8'h00, 1'b0);
        chk("rm_in_drain", {wd_req, done, failed}, 0);
        chk("rm_cycle11", cycle, 11);
        do_reset();
        idle_run(4);
        step(8'hFF, 1'b1);
        chk("rm_finish", finish, 1);
        chk("rm_quit", quit_cycle, 5);
        chk("rm_fatal", {fatal, failed}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
